// File: rtl/vga_timing_gen_if.sv
// Bundle between the VGA timing generator and the render pipeline.
// master = timing generator side, slave = consumer side.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 11,
  parameter int unsigned IDX_W = 13
) ();
  logic [3:0]       cell_width_m1;
  logic [4:0]       cell_height_m1;
  logic             active;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             cell_start;
  logic [3:0]       cell_sub_x;
  logic [4:0]       cell_sub_y;
  logic [IDX_W-1:0] character_index;
  logic             frame_start;
  logic             vblank_start;
  logic [7:0]       frame_counter;
  logic [7:0]       frame_counter_gray;
  logic             hsync;
  logic             vsync;
  logic             active_dly;

  modport master (
    input  cell_width_m1, cell_height_m1,
    output active, pixel_x, pixel_y, cell_start, cell_sub_x, cell_sub_y,
           character_index, frame_start, vblank_start, frame_counter,
           frame_counter_gray, hsync, vsync, active_dly
  );

  modport slave (
    output cell_width_m1, cell_height_m1,
    input  active, pixel_x, pixel_y, cell_start, cell_sub_x, cell_sub_y,
           character_index, frame_start, vblank_start, frame_counter,
           frame_counter_gray, hsync, vsync, active_dly
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing and character-cell sequencer. Every output is registered and
// describes the pixel (h, v) held in the counters; syncs are delayed by SYNC_DELAY.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned SYNC_DELAY = 8,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned IDX_W      = 13
) (
  input  logic             VGA_CLK,
  input  logic             reset,
  vga_timing_gen_if.master bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  // Delay-line word: {hsync, vsync, active}
  localparam logic [2:0] PIPE_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  logic             started;
  logic [CNT_W-1:0] h, v;
  logic             act_q, cell_start_q, frame_start_q, vblank_start_q;
  logic [3:0]       sub_x, width_sh;
  logic [4:0]       sub_y, height_sh;
  logic [IDX_W-1:0] index, line_base;
  logic [7:0]       fc, fc_gray;
  logic [2:0]       sync_pipe [SYNC_DELAY+1];

  logic [CNT_W-1:0] h_n, v_n;
  logic             line_wrap, line_end;
  logic             frame_start_n, vblank_start_n, active_n, cell_start_n;
  logic [3:0]       sub_x_n;
  logic [4:0]       sub_y_n;
  logic [IDX_W-1:0] index_n, line_base_n;
  logic [7:0]       fc_n;
  logic             hs_raw, vs_raw;

  // Next-pixel state; the first edge after reset lands on pixel (0, 0).
  always_comb begin
    h_n       = '0;
    v_n       = '0;
    line_wrap = 1'b0;
    if (started) begin
      if (h == H_LAST) begin
        line_wrap = 1'b1;
        v_n       = (v == V_LAST) ? '0 : v + CNT_W'(1);
      end else begin
        h_n = h + CNT_W'(1);
        v_n = v;
      end
    end

    line_end       = line_wrap && (v < V_ACT);
    frame_start_n  = (h_n == '0) && (v_n == '0);
    vblank_start_n = (h_n == '0) && (v_n == V_ACT);
    active_n       = (h_n < H_ACT) && (v_n < V_ACT);

    sub_x_n = sub_x;
    if (h_n == '0)  sub_x_n = '0;
    else if (act_q) sub_x_n = (sub_x == width_sh) ? 4'd0 : sub_x + 4'd1;

    sub_y_n = sub_y;
    if (frame_start_n) sub_y_n = '0;
    else if (line_end) sub_y_n = (sub_y == height_sh) ? 5'd0 : sub_y + 5'd1;

    cell_start_n = active_n && (sub_x_n == 4'd0);

    // A finished cell row moves the base past the last cell index it used.
    line_base_n = line_base;
    if (frame_start_n)                          line_base_n = '0;
    else if (line_end && (sub_y == height_sh))  line_base_n = index + IDX_W'(1);

    index_n = index;
    if (h_n == '0)        index_n = line_base_n;
    else if (cell_start_n) index_n = index + IDX_W'(1);

    fc_n   = vblank_start_n ? fc + 8'd1 : fc;
    hs_raw = ((h_n >= HS_BEG) && (h_n < HS_END)) ? HS_POL : ~HS_POL;
    vs_raw = ((v_n >= VS_BEG) && (v_n < VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      started        <= 1'b0;
      h              <= '0;
      v              <= '0;
      act_q          <= 1'b0;
      cell_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      sub_x          <= '0;
      sub_y          <= '0;
      index          <= '0;
      line_base      <= '0;
      fc             <= '0;
      fc_gray        <= '0;
      width_sh       <= bus.cell_width_m1;
      height_sh      <= bus.cell_height_m1;
      for (int i = 0; i <= int'(SYNC_DELAY); i++) sync_pipe[i] <= PIPE_IDLE;
    end else begin
      started        <= 1'b1;
      h              <= h_n;
      v              <= v_n;
      act_q          <= active_n;
      cell_start_q   <= cell_start_n;
      frame_start_q  <= frame_start_n;
      vblank_start_q <= vblank_start_n;
      sub_x          <= sub_x_n;
      sub_y          <= sub_y_n;
      index          <= index_n;
      line_base      <= line_base_n;
      fc             <= fc_n;
      fc_gray        <= fc_n ^ (fc_n >> 1);
      // Geometry is frozen for the whole frame about to start.
      if (frame_start_n) begin
        width_sh  <= bus.cell_width_m1;
        height_sh <= bus.cell_height_m1;
      end
      sync_pipe[0] <= {hs_raw, vs_raw, active_n};
      for (int i = 1; i <= int'(SYNC_DELAY); i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign bus.active             = act_q;
  assign bus.pixel_x            = h;
  assign bus.pixel_y            = v;
  assign bus.cell_start         = cell_start_q;
  assign bus.cell_sub_x         = sub_x;
  assign bus.cell_sub_y         = sub_y;
  assign bus.character_index    = index;
  assign bus.frame_start        = frame_start_q;
  assign bus.vblank_start       = vblank_start_q;
  assign bus.frame_counter      = fc;
  assign bus.frame_counter_gray = fc_gray;
  assign bus.hsync              = sync_pipe[SYNC_DELAY][2];
  assign bus.vsync              = sync_pipe[SYNC_DELAY][1];
  assign bus.active_dly         = sync_pipe[SYNC_DELAY][0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 16x9 raster: directed cell vectors plus
// full-raster scans against an arithmetic model (geometry change, reset, fc wrap).
module tb_vga_timing_gen;
  localparam int unsigned HA = 10, HF = 2, HSY = 2, HB = 2;
  localparam int unsigned VA = 6,  VF = 1, VSY = 1, VB = 1;
  localparam int unsigned HT = HA + HF + HSY + HB;
  localparam int unsigned VT = VA + VF + VSY + VB;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned SD = 3;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;
  localparam logic [2:0] IDLE = {~HSP, ~VSP, 1'b0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(11), .IDX_W(13)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .HS_POL(HSP), .VS_POL(VSP), .SYNC_DELAY(SD), .CNT_W(11), .IDX_W(13)
  ) dut (
    .VGA_CLK(clk),
    .reset  (reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] wm1;
    logic [4:0] hm1;
    int x, y;
    bit act, cs, cell_chk;
    int sx, sy, idx;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic add(input logic [3:0] w, input logic [4:0] hh, input int x, input int y,
                     input bit act, input bit cs, input bit cc, input int sx, input int sy,
                     input int idx);
    vec_t r;
    r = '{wm1: w, hm1: hh, x: x, y: y, act: act, cs: cs, cell_chk: cc, sx: sx, sy: sy, idx: idx};
    vecs.push_back(r);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_px"},    32'(bus.pixel_x), 0);
    chk({tag, "_py"},    32'(bus.pixel_y), 0);
    chk({tag, "_act"},   32'(bus.active), 0);
    chk({tag, "_cs"},    32'(bus.cell_start), 0);
    chk({tag, "_sx"},    32'(bus.cell_sub_x), 0);
    chk({tag, "_sy"},    32'(bus.cell_sub_y), 0);
    chk({tag, "_idx"},   32'(bus.character_index), 0);
    chk({tag, "_fs"},    32'(bus.frame_start), 0);
    chk({tag, "_vbs"},   32'(bus.vblank_start), 0);
    chk({tag, "_fc"},    32'(bus.frame_counter), 0);
    chk({tag, "_gray"},  32'(bus.frame_counter_gray), 0);
    chk({tag, "_hs"},    32'(bus.hsync), 32'(IDLE[2]));
    chk({tag, "_vs"},    32'(bus.vsync), 32'(IDLE[1]));
    chk({tag, "_adly"},  32'(bus.active_dly), 0);
  endtask

  // Cycle k after reset release is pixel (k mod HT, (k / HT) mod VT); cell fields
  // follow from plain division by the geometry latched at each frame start.
  task automatic scan(input int n, input int chg_k, input logic [3:0] cw, input logic [4:0] ch);
    int w, hh, mh, mv, cells, fc, idx;
    bit act, vb;
    logic [7:0] prev_gray;
    logic [2:0] raw, dly;
    logic [2:0] raw_q[$];
    w = 1; hh = 1; fc = 0; prev_gray = 8'h00;
    for (int k = 0; k < n; k++) begin
      step();
      mh = k % HT;
      mv = (k / HT) % VT;
      if (mh == 0 && mv == 0) begin
        w  = int'(bus.cell_width_m1) + 1;
        hh = int'(bus.cell_height_m1) + 1;
      end
      cells = (HA + w - 1) / w;
      act   = (mh < HA) && (mv < VA);
      vb    = (mh == 0) && (mv == VA);
      idx   = ((mv / hh) * cells + mh / w) % 8192;
      if (vb) begin
        fc = (fc + 1) % 256;
        chk("gray_onebit", 32'($countones(bus.frame_counter_gray ^ prev_gray)), 1);
        if (fc == 0) chk("gray_before_wrap", 32'(prev_gray), 32'h80);
      end
      raw = {((mh >= HA + HF) && (mh < HA + HF + HSY)) ? HSP : ~HSP,
             ((mv >= VA + VF) && (mv < VA + VF + VSY)) ? VSP : ~VSP, act};
      raw_q.push_back(raw);
      dly = (raw_q.size() > SD) ? raw_q.pop_front() : IDLE;

      chk("px",   32'(bus.pixel_x), 32'(mh));
      chk("py",   32'(bus.pixel_y), 32'(mv));
      chk("act",  32'(bus.active), 32'(act));
      chk("cs",   32'(bus.cell_start), 32'(act && (mh % w == 0)));
      chk("fs",   32'(bus.frame_start), 32'(mh == 0 && mv == 0));
      chk("vbs",  32'(bus.vblank_start), 32'(vb));
      chk("fc",   32'(bus.frame_counter), 32'(fc));
      chk("gray", 32'(bus.frame_counter_gray), 32'(fc ^ (fc >> 1)));
      chk("hs",   32'(bus.hsync), 32'(dly[2]));
      chk("vs",   32'(bus.vsync), 32'(dly[1]));
      chk("adly", 32'(bus.active_dly), 32'(dly[0]));
      if (act) begin
        chk("sx",  32'(bus.cell_sub_x), 32'(mh % w));
        chk("sy",  32'(bus.cell_sub_y), 32'(mv % hh));
        chk("idx", 32'(bus.character_index), 32'(idx));
      end
      prev_gray = bus.frame_counter_gray;
      if (k == chg_k) begin
        bus.cell_width_m1  = cw;
        bus.cell_height_m1 = ch;
      end
    end
  endtask

  initial begin
    //  wm1 hm1  x  y  act cs chk sx sy idx
    add(2, 1,  0, 0, 1, 1, 1, 0, 0, 0);
    add(2, 1,  3, 0, 1, 1, 1, 0, 0, 1);
    add(2, 1,  4, 0, 1, 0, 1, 1, 0, 1);
    add(2, 1,  9, 0, 1, 1, 1, 0, 0, 3);
    add(2, 1,  9, 1, 1, 1, 1, 0, 1, 3);
    add(2, 1,  0, 2, 1, 1, 1, 0, 0, 4);
    add(2, 1,  8, 5, 1, 0, 1, 2, 1, 10);
    add(2, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    add(2, 1,  3, 6, 0, 0, 0, 0, 0, 0);
    add(3, 3,  8, 0, 1, 1, 1, 0, 0, 2);
    add(3, 3,  9, 3, 1, 0, 1, 1, 3, 2);
    add(3, 3,  0, 4, 1, 1, 1, 0, 0, 3);
    add(3, 3,  8, 5, 1, 1, 1, 0, 1, 5);
    add(0, 0,  0, 0, 1, 1, 1, 0, 0, 0);
    add(0, 0,  5, 3, 1, 1, 1, 0, 0, 35);
    add(0, 0,  9, 5, 1, 1, 1, 0, 0, 59);
    add(15, 31, 0, 5, 1, 1, 1, 0, 5, 0);
    add(15, 31, 9, 5, 1, 0, 1, 9, 5, 0);

    bus.cell_width_m1  = 4'd2;
    bus.cell_height_m1 = 5'd1;
    reset = 1'b1;
    step();
    step();
    check_reset_state("rst");

    foreach (vecs[i]) begin
      bus.cell_width_m1  = vecs[i].wm1;
      bus.cell_height_m1 = vecs[i].hm1;
      do_reset();
      repeat (vecs[i].y * int'(HT) + vecs[i].x + 1) step();
      chk($sformatf("v%0d_px", i),  32'(bus.pixel_x), 32'(vecs[i].x));
      chk($sformatf("v%0d_py", i),  32'(bus.pixel_y), 32'(vecs[i].y));
      chk($sformatf("v%0d_act", i), 32'(bus.active), 32'(vecs[i].act));
      chk($sformatf("v%0d_cs", i),  32'(bus.cell_start), 32'(vecs[i].cs));
      if (vecs[i].cell_chk) begin
        chk($sformatf("v%0d_sx", i),  32'(bus.cell_sub_x), 32'(vecs[i].sx));
        chk($sformatf("v%0d_sy", i),  32'(bus.cell_sub_y), 32'(vecs[i].sy));
        chk($sformatf("v%0d_idx", i), 32'(bus.character_index), 32'(vecs[i].idx));
      end
    end

    // Width/height change on line 3 of frame 1 only takes hold at frame 2;
    // the scan stops on pixel (13, 7) where both raw syncs are asserted.
    bus.cell_width_m1  = 4'd2;
    bus.cell_height_m1 = 5'd1;
    do_reset();
    scan(2 * FT + 7 * HT + 13 + 1, FT + 3 * HT, 4'd3, 5'd3);

    reset = 1'b1;
    step();
    check_reset_state("midrst");
    reset = 1'b0;

    // More than 256 frames so frame_counter wraps 255 -> 0.
    scan(257 * FT + 8, -1, 4'd3, 5'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
